// File: rtl/issue_unit.sv
// issue_unit: pops instructions from the 8-entry instruction queue, decodes
// them and strobes them into the add/sub, mul/div or load/store reservation
// station group once that group has a free entry.
// Optional feature macro: ISSUE_COUNT_EN (issued-instruction counter on issueCnt).
module issue_unit #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             qVazio,
   output logic             qRtr,
   input  logic [15:0]      qInstr,
   input  logic             rsAddFree,
   input  logic             rsMulFree,
   input  logic             rsLdFree,
   output logic             issueAdd,
   output logic             issueMul,
   output logic             issueLd,
   output logic [3:0]       issueOp,
   output logic [3:0]       issueRd,
   output logic [3:0]       issueRs,
   output logic [3:0]       issueRt,
   output logic             stall,
   output logic             illegal,
   output logic [CNT_W-1:0] issueCnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DISP = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_ir;

   logic w_is_add;
   logic w_is_mul;
   logic w_is_ld;
   logic w_is_nop;
   logic w_is_ill;
   logic w_ready;
   logic w_done;

   // Classify the opcode held in IR; only the targeted group's free flag matters.
   always_comb begin
      w_is_add = 1'b0;
      w_is_mul = 1'b0;
      w_is_ld  = 1'b0;
      w_is_nop = 1'b0;
      w_is_ill = 1'b0;
      case (r_ir[15:12])
         4'd0, 4'd1: w_is_add = 1'b1;
         4'd2, 4'd3: w_is_mul = 1'b1;
         4'd4, 4'd5: w_is_ld  = 1'b1;
         4'd15:      w_is_nop = 1'b1;
         default:    w_is_ill = 1'b1;
      endcase
      w_ready = (w_is_add & rsAddFree) | (w_is_mul & rsMulFree) |
                (w_is_ld & rsLdFree) | w_is_nop | w_is_ill;
   end

   // Handshake and strobe outputs derived from the current state and IR.
   always_comb begin
      w_done = 1'b0;
      if (r_state == DISP) begin
         w_done = w_ready;
      end else begin
         w_done = 1'b0;
      end
      qRtr     = ((r_state == IDLE) | w_done) & ~qVazio;
      issueAdd = w_done & w_is_add;
      issueMul = w_done & w_is_mul;
      issueLd  = w_done & w_is_ld;
      illegal  = w_done & w_is_ill;
      stall    = (r_state == DISP) & ~w_ready;
   end

   // Sequencer: fetch (IDLE), latch the popped word (LOAD), wait/issue (DISP).
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state <= IDLE;
         r_ir    <= 16'h0000;
      end else begin
         case (r_state)
            IDLE: begin
               if (!qVazio) begin
                  r_state <= LOAD;
               end else begin
                  r_state <= IDLE;
               end
            end
            LOAD: begin
               r_ir    <= qInstr;
               r_state <= DISP;
            end
            DISP: begin
               if (w_ready) begin
                  r_state <= qVazio ? IDLE : LOAD;
               end else begin
                  r_state <= DISP;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Field outputs come straight from IR, so they hold between instructions.
   assign issueOp = r_ir[15:12];
   assign issueRd = r_ir[11:8];
   assign issueRs = r_ir[7:4];
   assign issueRt = r_ir[3:0];

`ifdef ISSUE_COUNT_EN
   logic [CNT_W-1:0] r_cnt;
   logic             w_strobe;

   assign w_strobe = issueAdd | issueMul | issueLd;

   // Count real issues only; NOP and illegal never strobe, so never count.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_cnt <= '0;
      end else if (w_strobe) begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign issueCnt = r_cnt;
`else
   assign issueCnt = '0;
`endif

endmodule

// File: doc/issue_unit.md
# issue_unit

Reads instructions out of the 8-entry instruction queue and issues them to the Tomasulo reservation stations. It is the consumer end of the queue's retrieve handshake: it pops one instruction, decodes it, waits for a free slot in the target reservation-station group, then strobes the issue. Sits between the instruction queue and the add/sub, mul/div and load/store reservation stations.

## Interface
Parameters:
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  reset; asynchronous, active-high.
- qVazio  in  1  queue empty flag.
- qRtr  out  1  retrieve request to the queue; combinational.
- qInstr  in  16  queue output word; updated by the queue on the edge where qRtr=1 and qVazio=0.
- rsAddFree, rsMulFree, rsLdFree  in  1 each  target reservation-station group has a free entry.
- issueAdd, issueMul, issueLd  out  1 each  one-cycle issue strobes; combinational.
- issueOp  out  4  opcode of the issued instruction; registered.
- issueRd, issueRs, issueRt  out  4 each  register fields; registered.
- stall  out  1  high while an instruction waits for its reservation station; combinational.
- illegal  out  1  one-cycle pulse when an undefined opcode is discarded; combinational.
- issueCnt  out  CNT_W  issued-instruction count (see Configuration).

## Operation
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
- Opcode classes:
  - 0 ADD and 1 SUB go to the add group.
  - 2 MUL and 3 DIV go to the mul group.
  - 4 LD and 5 ST go to the ld group.
  - 15 is NOP.
  - 6–14 are illegal.
- IR is the internal 16-bit instruction register.
- FSM states: IDLE, LOAD, DISP.
  - IDLE: qRtr = ~qVazio. If qVazio=0, go to LOAD; otherwise stay in IDLE.
  - LOAD: qInstr is valid in this cycle. Latch qInstr into IR and drive issueOp, issueRd, issueRs, issueRt from it. Go to DISP. qRtr=0.
  - DISP, target group free, or NOP, or illegal: the instruction completes this cycle.
    - Assert the matching strobe. NOP asserts no strobe. Illegal asserts `illegal` and no strobe.
    - Also assert qRtr = ~qVazio. Go to LOAD if qVazio=0, otherwise to IDLE.
  - DISP, target group busy: stall=1, qRtr=0, and no strobe. Stay in DISP. IR and the field outputs hold.
- At most one issue strobe is high in any cycle. Strobes only fire in DISP.
- Outputs hold their last value between instructions.

## Timing
- Values after CLR: state IDLE, IR=0, and issueOp/Rd/Rs/Rt=0. qRtr, stall, illegal and the issue strobes are all 0. issueCnt=0.
- CLR asserted mid-operation: an instruction already popped into IR is dropped. The queue is cleared by the same CLR.
- Latency: the retrieve edge is edge 0. LOAD is the cycle after edge 0, and DISP follows LOAD. With a free target group, the issue strobe comes 2 cycles after qRtr.
- Throughput: one instruction per 2 cycles when the queue is non-empty and targets are free (LOAD/DISP alternate).
- qVazio sampled in DISP is the queue state at that cycle. A word enqueued in the same cycle is not seen until the next cycle.
- A reservation-station free flag that rises during a stall gives the strobe in that same cycle.
- Free flags are sampled only for the class that IR targets. Other groups are ignored.

## Configuration
- ISSUE_COUNT_EN defined:
  - issueCnt increments by 1 on each edge where an issue strobe is high.
  - NOP and illegal instructions do not count.
  - The counter wraps modulo 2^CNT_W.
- ISSUE_COUNT_EN undefined: issueCnt is tied to 0, with no counter logic. The port remains.

## Test plan
- Reset then empty queue (qVazio=1 for 10 cycles) -> qRtr=0, all strobes 0, state stays IDLE.
- Queue holds 0x0123 (ADD r1,r2,r3), all groups free -> qRtr pulse, then LOAD, then issueAdd=1 for one cycle with issueOp=0, issueRd=1, issueRs=2, issueRt=3.
- Queue holds 0x2456 (MUL), rsMulFree=0 for 3 cycles then 1 -> stall=1 for 3 cycles, then issueMul in the cycle rsMulFree rises; no second strobe.
- Queue holds 0x4000, 0x5111, 0xF000, 0x9000 back-to-back -> issueLd, then issueLd, then NOP with no strobe, then illegal pulse, each 2 cycles apart; with ISSUE_COUNT_EN, issueCnt=2.
- CLR pulsed while in DISP with rsAddFree=0 -> all outputs return to their reset values immediately, and no strobe follows.
- With ISSUE_COUNT_EN and CNT_W=4, issue 17 ADDs -> issueCnt=1 (wrapped).
